fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fba_pkg.sv | 18 +
 rtl/fb_write_arbiter_if.sv | 31 +++
 rtl/fba_rr_arbiter.sv | 42 ++++
 rtl/fb_write_arbiter.sv | 113 +++++++++++
 tb/tb_fb_write_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fba_pkg.sv
// Shared types and defaults for the framebuffer write arbiter.
package fba_pkg;

  localparam int unsigned FbWDefault  = 8;
  localparam int unsigned RgbWDefault = 3;

  typedef enum logic {
    ARB,
    CLEAR
  } fba_state_e;

  typedef struct packed {
    logic [FbWDefault-1:0]    x;
    logic [FbWDefault-1:0]    y;
    logic [3*RgbWDefault-1:0] rgb;
  } fba_pixel_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester, clear-control and framebuffer-write signals of the write arbiter.
interface fb_write_arbiter_if #(
  parameter int unsigned FB_W  = 8,
  parameter int unsigned RGB_W = 3
);
  logic               s0_valid, s0_ready;
  logic [FB_W-1:0]    s0_x, s0_y;
  logic [3*RGB_W-1:0] s0_rgb;
  logic               s1_valid, s1_ready;
  logic [FB_W-1:0]    s1_x, s1_y;
  logic [3*RGB_W-1:0] s1_rgb;
  logic               clear_start;
  logic [3*RGB_W-1:0] clear_rgb;
  logic [FB_W-1:0]    write_x, write_y;
  logic [RGB_W-1:0]   write_r, write_g, write_b;
  logic               write_en;
  logic               busy;
  logic               clear_done;

  modport master (
    output s0_valid, s0_x, s0_y, s0_rgb, s1_valid, s1_x, s1_y, s1_rgb, clear_start, clear_rgb,
    input  s0_ready, s1_ready, write_x, write_y, write_r, write_g, write_b, write_en, busy,
           clear_done
  );

  modport slave (
    input  s0_valid, s0_x, s0_y, s0_rgb, s1_valid, s1_x, s1_y, s1_rgb, clear_start, clear_rgb,
    output s0_ready, s1_ready, write_x, write_y, write_r, write_g, write_b, write_en, busy,
           clear_done
  );
endinterface

// File: rtl/fba_rr_arbiter.sv
// Two-way grant logic: round-robin by default, fixed s0 priority with FBA_FIXED_PRI_EN.
module fba_rr_arbiter (
  input  logic       clock,
  input  logic       not_reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef FBA_FIXED_PRI_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clock ^ not_reset;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end
  end
`else
  // 1 means s1 was granted last, so s0 wins the first contention after reset.
  logic last_grant_q;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      last_grant_q <= 1'b1;
    end else if (|grant) begin
      last_grant_q <= grant[1];
    end
  end
`endif

endmodule

// File: rtl/fb_write_arbiter.sv
// Arbitrates two pixel writers onto one framebuffer port and runs full-screen clears.
// Optional FBA_FIXED_PRI_EN selects fixed s0 priority instead of round-robin.
module fb_write_arbiter
  import fba_pkg::*;
#(
  parameter int unsigned FB_W  = FbWDefault,
  parameter int unsigned RGB_W = RgbWDefault
) (
  input logic               clock,
  input logic               not_reset,
  fb_write_arbiter_if.slave bus
);

  localparam int unsigned CW = 3 * RGB_W;

  typedef struct packed {
    logic [FB_W-1:0] x;
    logic [FB_W-1:0] y;
    logic [CW-1:0]   rgb;
  } pix_t;

  fba_state_e      state_q, state_d;
  logic [FB_W-1:0] sweep_x_q, sweep_x_d, sweep_y_q, sweep_y_d;
  logic [CW-1:0]   clear_rgb_q, clear_rgb_d;
  pix_t            wr_q, wr_d;
  logic            write_en_q, write_en_d;
  logic            clear_done_q, clear_done_d;
  logic [1:0]      req, grant;
  logic            arb_en;

  // Gating with reset keeps ready low while reset is held.
  assign arb_en = (state_q == ARB) && not_reset;
  assign req    = {bus.s1_valid, bus.s0_valid};

  fba_rr_arbiter u_arb (
    .clock     (clock),
    .not_reset (not_reset),
    .en        (arb_en),
    .req       (req),
    .grant     (grant)
  );

  always_comb begin
    state_d      = state_q;
    sweep_x_d    = sweep_x_q;
    sweep_y_d    = sweep_y_q;
    clear_rgb_d  = clear_rgb_q;
    wr_d         = wr_q;
    write_en_d   = 1'b0;
    clear_done_d = 1'b0;
    unique case (state_q)
      ARB: begin
        if (grant[0]) begin
          wr_d       = '{x: bus.s0_x, y: bus.s0_y, rgb: bus.s0_rgb};
          write_en_d = 1'b1;
        end else if (grant[1]) begin
          wr_d       = '{x: bus.s1_x, y: bus.s1_y, rgb: bus.s1_rgb};
          write_en_d = 1'b1;
        end
        if (bus.clear_start) begin
          clear_rgb_d = bus.clear_rgb;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        // The done cycle shows the last pixel; requesters stay blocked until it has passed.
        if (clear_done_q) begin
          state_d = ARB;
        end else begin
          wr_d       = '{x: sweep_x_q, y: sweep_y_q, rgb: clear_rgb_q};
          write_en_d = 1'b1;
          sweep_x_d  = sweep_x_q + 1'b1;
          if (&sweep_x_q) begin
            sweep_y_d = sweep_y_q + 1'b1;
            if (&sweep_y_q) clear_done_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_q      <= ARB;
      sweep_x_q    <= '0;
      sweep_y_q    <= '0;
      clear_rgb_q  <= '0;
      wr_q         <= '0;
      write_en_q   <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_x_q    <= sweep_x_d;
      sweep_y_q    <= sweep_y_d;
      clear_rgb_q  <= clear_rgb_d;
      wr_q         <= wr_d;
      write_en_q   <= write_en_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign bus.s0_ready   = grant[0];
  assign bus.s1_ready   = grant[1];
  assign bus.write_x    = wr_q.x;
  assign bus.write_y    = wr_q.y;
  assign bus.write_r    = wr_q.rgb[CW-1 -: RGB_W];
  assign bus.write_g    = wr_q.rgb[2*RGB_W-1 -: RGB_W];
  assign bus.write_b    = wr_q.rgb[RGB_W-1:0];
  assign bus.write_en   = write_en_q;
  assign bus.clear_done = clear_done_q;
  assign bus.busy       = (state_q == CLEAR) && !clear_done_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter on a 32x32 framebuffer (FB_W=5) to keep sweeps short.
module tb_fb_write_arbiter;

  localparam int unsigned FbW  = 5;
  localparam int unsigned RgbW = 3;
  localparam int          NPix = 1 << (2 * FbW);
  localparam int          Side = 1 << FbW;

  logic clock;
  logic not_reset;
  int   n_checks;
  int   n_fail;

  fb_write_arbiter_if #(.FB_W(FbW), .RGB_W(RgbW)) bus ();

  fb_write_arbiter #(.FB_W(FbW), .RGB_W(RgbW)) dut (
    .clock     (clock),
    .not_reset (not_reset),
    .bus       (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s0_valid    = 1'b0;
    bus.s0_x        = '0;
    bus.s0_y        = '0;
    bus.s0_rgb      = '0;
    bus.s1_valid    = 1'b0;
    bus.s1_x        = '0;
    bus.s1_y        = '0;
    bus.s1_rgb      = '0;
    bus.clear_start = 1'b0;
    bus.clear_rgb   = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    not_reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    not_reset = 1'b1;
  endtask

  initial begin
    int busy_cnt, wcnt, seq_err, col_err, done_cnt, done_c, done_x, done_y, first_s1;
    int p, wr_seen, busy_seen;
    bit found;
    logic exp_s0;
    n_checks  = 0;
    n_fail    = 0;
    not_reset = 1'b0;
    idle_inputs();

    // Reset state, ready gated while reset held
    bus.s0_valid = 1'b1;
    #3;
    check_eq("rst_write_en", 32'(bus.write_en), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_clear_done", 32'(bus.clear_done), 0);
    check_eq("rst_write_x", 32'(bus.write_x), 0);
    check_eq("rst_write_y", 32'(bus.write_y), 0);
    check_eq("rst_s0_ready", 32'(bus.s0_ready), 0);
    bus.s0_valid = 1'b0;
    @(negedge clock);
    not_reset = 1'b1;

    // Single requester: same-cycle ready, latency-1 write
    bus.s0_valid = 1'b1;
    bus.s0_x     = 5'd10;
    bus.s0_y     = 5'd20;
    bus.s0_rgb   = 9'o777;
    #1;
    check_eq("single_s0_ready", 32'(bus.s0_ready), 1);
    check_eq("single_s1_ready", 32'(bus.s1_ready), 0);
    step();
    bus.s0_valid = 1'b0;
    check_eq("single_wen", 32'(bus.write_en), 1);
    check_eq("single_x", 32'(bus.write_x), 10);
    check_eq("single_y", 32'(bus.write_y), 20);
    check_eq("single_r", 32'(bus.write_r), 7);
    check_eq("single_g", 32'(bus.write_g), 7);
    check_eq("single_b", 32'(bus.write_b), 7);
    step();
    check_eq("idle_wen", 32'(bus.write_en), 0);
    check_eq("idle_hold_x", 32'(bus.write_x), 10);
    check_eq("idle_hold_y", 32'(bus.write_y), 20);

    // Contention from reset
    do_reset();
    bus.s0_valid = 1'b1;
    bus.s0_x     = 5'd1;
    bus.s0_rgb   = 9'o001;
    bus.s1_valid = 1'b1;
    bus.s1_x     = 5'd2;
    bus.s1_rgb   = 9'o002;
    for (int k = 0; k < 4; k++) begin
`ifdef FBA_FIXED_PRI_EN
      exp_s0 = 1'b1;
`else
      exp_s0 = (k % 2) == 0;
`endif
      #1;
      check_eq($sformatf("contend_s0_ready_%0d", k), 32'(bus.s0_ready), 32'(exp_s0));
      check_eq($sformatf("contend_s1_ready_%0d", k), 32'(bus.s1_ready), 32'(!exp_s0));
      step();
      check_eq($sformatf("contend_write_x_%0d", k), 32'(bus.write_x), exp_s0 ? 1 : 2);
    end
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;

    // Clear with same-cycle s0 transfer, s1 waiting, restart attempt mid-sweep
    do_reset();
    bus.s0_valid    = 1'b1;
    bus.s0_x        = 5'd3;
    bus.s0_y        = 5'd4;
    bus.s0_rgb      = 9'o456;
    bus.s1_valid    = 1'b1;
    bus.s1_x        = 5'd7;
    bus.s1_y        = 5'd9;
    bus.s1_rgb      = 9'o321;
    bus.clear_start = 1'b1;
    bus.clear_rgb   = 9'o123;
    #1;
    check_eq("clr_launch_s0_ready", 32'(bus.s0_ready), 1);
    check_eq("clr_launch_s1_ready", 32'(bus.s1_ready), 0);
    busy_cnt = 0; wcnt = 0; seq_err = 0; col_err = 0;
    done_cnt = 0; done_c = 0; done_x = 0; done_y = 0; first_s1 = 0;
    for (int c = 1; c <= NPix + 4; c++) begin
      step();
      if (bus.busy) busy_cnt++;
      if (c == 1) begin
        check_eq("clr_s0_wen", 32'(bus.write_en), 1);
        check_eq("clr_s0_x", 32'(bus.write_x), 3);
        check_eq("clr_s0_y", 32'(bus.write_y), 4);
        check_eq("clr_busy_first", 32'(bus.busy), 1);
        bus.s0_valid    = 1'b0;
        bus.clear_start = 1'b0;
      end
      if (c == 2) begin
        check_eq("clr_first_x", 32'(bus.write_x), 0);
        check_eq("clr_first_y", 32'(bus.write_y), 0);
      end
      if (c >= 2 && c <= NPix + 1 && bus.write_en) begin
        p = c - 2;
        wcnt++;
        if (int'(bus.write_x) != p % Side || int'(bus.write_y) != p / Side) seq_err++;
        if (bus.write_r != 3'd1 || bus.write_g != 3'd2 || bus.write_b != 3'd3) col_err++;
      end
      if (bus.clear_done) begin
        done_cnt++;
        done_c = c;
        done_x = int'(bus.write_x);
        done_y = int'(bus.write_y);
      end
      if (first_s1 != 0 && c == first_s1 + 1) begin
        check_eq("post_clr_s1_wen", 32'(bus.write_en), 1);
        check_eq("post_clr_s1_x", 32'(bus.write_x), 7);
        check_eq("post_clr_s1_y", 32'(bus.write_y), 9);
        bus.s1_valid = 1'b0;
      end
      if (bus.s1_ready && first_s1 == 0) first_s1 = c;
      if (c == 500) begin
        bus.clear_start = 1'b1;
        bus.clear_rgb   = 9'o765;
      end
      if (c == 501) bus.clear_start = 1'b0;
    end
    check_eq("clr_busy_cycles", busy_cnt, NPix);
    check_eq("clr_write_count", wcnt, NPix);
    check_eq("clr_sequence_errors", seq_err, 0);
    check_eq("clr_colour_errors", col_err, 0);
    check_eq("clr_done_pulses", done_cnt, 1);
    check_eq("clr_done_cycle", done_c, NPix + 1);
    check_eq("clr_done_x", done_x, Side - 1);
    check_eq("clr_done_y", done_y, Side - 1);
    check_eq("clr_s1_first_grant", first_s1, NPix + 2);

    // Reset mid-sweep at pixel 1000
    do_reset();
    bus.clear_start = 1'b1;
    bus.clear_rgb   = 9'o777;
    step();
    bus.clear_start = 1'b0;
    found = 1'b0;
    for (int c = 2; c < 1100 && !found; c++) begin
      step();
      if (bus.write_en && bus.write_x == 5'(1000 % Side) && bus.write_y == 5'(1000 / Side))
        found = 1'b1;
    end
    check_eq("px1000_reached", 32'(found), 1);
    not_reset = 1'b0;
    #1;
    check_eq("abort_wen", 32'(bus.write_en), 0);
    check_eq("abort_busy", 32'(bus.busy), 0);
    check_eq("abort_write_x", 32'(bus.write_x), 0);
    @(negedge clock);
    not_reset = 1'b1;
    wr_seen   = 0;
    busy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.write_en) wr_seen++;
      if (bus.busy) busy_seen++;
    end
    check_eq("abort_no_writes", wr_seen, 0);
    check_eq("abort_no_busy", busy_seen, 0);
    bus.s0_valid = 1'b1;
    #1;
    check_eq("abort_back_in_arb", 32'(bus.s0_ready), 1);
    bus.s0_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
